seg7_scan_driver: RTL and testbench

//   Drives a 4-digit multiplexed common-anode 7-segment display.

---
 rtl/seg7_scan_driver.sv | 116 +++++++++++
 tb/tb_seg7_scan_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Drives a 4-digit multiplexed common-anode 7-segment display. A prescaler
//   produces one tick every SCAN_DIV clocks; each tick advances the digit
//   index (0,1,2,3,0...) and registers the anode/segment pattern for that
//   digit. bcd_value is latched once per frame, on the tick where the index
//   wraps 3->0, so all four digits of a frame come from the same value.
//   flash_slow | flash_fast, sampled on each tick, blanks that slot.
//
// Parameters
//   SCAN_DIV    clk cycles per digit slot (>= 2)
//   ACTIVE_LOW  1: an/seg active-low, 0: active-high
//
// Optional feature
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits 3..1 are blanked
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   bcd_value   {thousands,hundreds,tens,ones} BCD nibbles
//   flash_slow  blank request
//   flash_fast  blank request
//   an          digit enables, an[0] = ones digit
//   seg         segments {g,f,e,d,c,b,a}

module seg7_scan_driver #(
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_value,
    input  logic        flash_slow,
    input  logic        flash_fast,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] prescale;
    logic [1:0]    digit_idx;
    logic [15:0]   frame;
    logic          tick;

    logic [1:0]    next_idx;
    logic [15:0]   frame_next;
    logic [3:0]    nibble;
    logic [6:0]    decoded;
    logic          lz_blank;
    logic          blank;
    logic [3:0]    an_active;
    logic [6:0]    seg_active;

    assign tick = (prescale == CW'(SCAN_DIV - 1));

    // Work out what the next slot will show. On the wrapping tick the
    // incoming bcd_value is used directly so digit 0 of a new frame already
    // shows the value that is being latched in the same cycle.
    always_comb begin
        next_idx   = digit_idx + 2'd1;
        frame_next = (digit_idx == 2'd3) ? bcd_value : frame;
        nibble     = frame_next[{next_idx, 2'b00} +: 4];

        case (nibble)
            4'h0:    decoded = 7'h3F;
            4'h1:    decoded = 7'h06;
            4'h2:    decoded = 7'h5B;
            4'h3:    decoded = 7'h4F;
            4'h4:    decoded = 7'h66;
            4'h5:    decoded = 7'h6D;
            4'h6:    decoded = 7'h7D;
            4'h7:    decoded = 7'h07;
            4'h8:    decoded = 7'h7F;
            4'h9:    decoded = 7'h6F;
            default: decoded = 7'h40;
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every higher nibble are zero;
        // the ones digit always stays visible.
        case (next_idx)
            2'd3:    lz_blank = (frame_next[15:12] == 4'h0);
            2'd2:    lz_blank = (frame_next[15:8]  == 8'h00);
            2'd1:    lz_blank = (frame_next[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif

        blank      = flash_fast | flash_slow | lz_blank;
        an_active  = blank ? 4'b0000  : (4'b0001 << next_idx);
        seg_active = blank ? 7'b0000000 : decoded;
    end

    // Prescaler, scan index, frame latch and registered outputs. Everything
    // except the prescaler only moves on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale  <= '0;
            digit_idx <= 2'd3;
            frame     <= 16'h0000;
            an        <= {4{ACTIVE_LOW}};
            seg       <= {7{ACTIVE_LOW}};
        end else begin
            prescale <= tick ? '0 : prescale + CW'(1);
            if (tick) begin
                digit_idx <= next_idx;
                frame     <= frame_next;
                an        <= an_active ^ {4{ACTIVE_LOW}};
                seg       <= seg_active ^ {7{ACTIVE_LOW}};
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Self-checking bench for seg7_scan_driver with SCAN_DIV=4, ACTIVE_LOW=1.
//   A reference model counts cycles since reset and slots since reset and
//   derives the expected display from those counts; outputs are compared
//   every cycle, plus fixed expected patterns at the interesting points.

module tb_seg7_scan_driver;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_value;
    logic        flash_slow;
    logic        flash_fast;
    logic [3:0]  an;
    logic [6:0]  seg;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int          cyc;
    int          slot;
    logic [15:0] frame_m;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                 7'h40, 7'h40, 7'h40, 7'h40};

    logic [3:0] an_seq  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg1234 [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    logic [6:0] seg5678 [4] = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};

    seg7_scan_driver #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_value  (bcd_value),
        .flash_slow (flash_slow),
        .flash_fast (flash_fast),
        .an         (an),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Model: a tick falls on every SD-th cycle after reset release; slot n
    // shows digit n mod 4 and slot 0 of each frame takes a fresh bcd_value.
    task automatic modelEdge(input logic [15:0] b, input logic fs, input logic ff, input logic rst);
        int   d;
        logic lz;
        logic [3:0] nib;
        if (rst) begin
            cyc     = 0;
            slot    = 0;
            frame_m = 16'h0000;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end else begin
            if (cyc % SD == SD - 1) begin
                d = slot % 4;
                if (d == 0) frame_m = b;
                nib = 4'((frame_m >> (4 * d)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
                lz = (d != 0) && ((frame_m >> (4 * d)) == 16'h0);
`else
                lz = 1'b0;
`endif
                if (fs || ff || lz) begin
                    exp_an  = 4'hF;
                    exp_seg = 7'h7F;
                end else begin
                    exp_an  = ~(4'b0001 << d);
                    exp_seg = ~seg_tab[nib];
                end
                slot++;
            end
            cyc++;
        end
    endtask

    // One clock with the given inputs, then a model comparison #1 later.
    task automatic applyStimulus(input logic [15:0] b, input logic fs, input logic ff, input logic rst);
        bcd_value  = b;
        flash_slow = fs;
        flash_fast = ff;
        reset      = rst;
        @(posedge clk);
        modelEdge(b, fs, ff, rst);
        #1;
        checkOutput("model_an",  {3'b000, an}, {3'b000, exp_an});
        checkOutput("model_seg", seg, exp_seg);
    endtask

    task automatic tickOnce(input logic [15:0] b, input logic fs, input logic ff);
        for (int k = 0; k < SD; k++) applyStimulus(b, fs, ff, 1'b0);
    endtask

    initial begin
        bcd_value  = 16'h0000;
        flash_slow = 1'b0;
        flash_fast = 1'b0;
        reset      = 1'b1;
        @(negedge clk);

        // Reset, then outputs stay off until the first tick.
        applyStimulus(16'h1234, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h1234, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_an",  {3'b000, an}, 7'b0001111);
        checkOutput("reset_seg", seg, 7'b1111111);
        for (int k = 0; k < SD - 1; k++) begin
            applyStimulus(16'h1234, 1'b0, 1'b0, 1'b0);
            checkOutput("hold_an", {3'b000, an}, 7'b0001111);
        end
        applyStimulus(16'h1234, 1'b0, 1'b0, 1'b0);
        checkOutput("first_tick_an",  {3'b000, an}, 7'b0001110);
        checkOutput("first_tick_seg", seg, seg1234[0]);

        // Steady scan of 1234, two more frames.
        for (int i = 1; i <= 8; i++) begin
            tickOnce(16'h1234, 1'b0, 1'b0);
            checkOutput("scan_an",  {3'b000, an}, {3'b000, an_seq[i % 4]});
            checkOutput("scan_seg", seg, seg1234[i % 4]);
        end

        // Value changes mid-frame: digits 2,3 still from the old frame.
        tickOnce(16'h1234, 1'b0, 1'b0);
        checkOutput("pre_change_an", {3'b000, an}, 7'b0001101);
        tickOnce(16'h5678, 1'b0, 1'b0);
        checkOutput("no_tear_d2", seg, 7'b0100100);
        tickOnce(16'h5678, 1'b0, 1'b0);
        checkOutput("no_tear_d3", seg, 7'b1111001);
        for (int i = 0; i < 4; i++) begin
            tickOnce(16'h5678, 1'b0, 1'b0);
            checkOutput("new_frame_an",  {3'b000, an}, {3'b000, an_seq[i]});
            checkOutput("new_frame_seg", seg, seg5678[i]);
        end

        // Flash blanking with flash_fast, then flash_slow.
        for (int i = 0; i < 2; i++) begin
            tickOnce(16'h5678, 1'b0, 1'b1);
            checkOutput("fast_blank_an",  {3'b000, an}, 7'b0001111);
            checkOutput("fast_blank_seg", seg, 7'b1111111);
        end
        tickOnce(16'h5678, 1'b0, 1'b0);
        checkOutput("fast_resume_an",  {3'b000, an}, 7'b0001011);
        checkOutput("fast_resume_seg", seg, 7'b0000010);
        for (int i = 0; i < 2; i++) begin
            tickOnce(16'h5678, 1'b1, 1'b0);
            checkOutput("slow_blank_an",  {3'b000, an}, 7'b0001111);
            checkOutput("slow_blank_seg", seg, 7'b1111111);
        end
        tickOnce(16'h5678, 1'b0, 1'b0);
        checkOutput("slow_resume_an",  {3'b000, an}, 7'b0001101);
        checkOutput("slow_resume_seg", seg, 7'b1111000);
        tickOnce(16'h5678, 1'b0, 1'b0);
        tickOnce(16'h5678, 1'b0, 1'b0);

        // 0007: leading zeros shown or blanked depending on the build.
        tickOnce(16'h0007, 1'b0, 1'b0);
        checkOutput("d0_0007_an",  {3'b000, an}, 7'b0001110);
        checkOutput("d0_0007_seg", seg, 7'b1111000);
        for (int i = 1; i < 4; i++) begin
            tickOnce(16'h0007, 1'b0, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
            checkOutput("lz_an",  {3'b000, an}, 7'b0001111);
            checkOutput("lz_seg", seg, 7'b1111111);
`else
            checkOutput("zero_an",  {3'b000, an}, {3'b000, an_seq[i]});
            checkOutput("zero_seg", seg, 7'b1000000);
`endif
        end

        // 00A0: nibble A shows a dash; then reset in the middle of a slot.
        tickOnce(16'h00A0, 1'b0, 1'b0);
        tickOnce(16'h00A0, 1'b0, 1'b0);
        checkOutput("dash_an",  {3'b000, an}, 7'b0001101);
        checkOutput("dash_seg", seg, 7'b0111111);
        applyStimulus(16'h00A0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h00A0, 1'b0, 1'b0, 1'b1);
        checkOutput("mid_reset_an",  {3'b000, an}, 7'b0001111);
        checkOutput("mid_reset_seg", seg, 7'b1111111);
        tickOnce(16'h00A0, 1'b0, 1'b0);
        checkOutput("restart_an",  {3'b000, an}, 7'b0001110);
        checkOutput("restart_seg", seg, 7'b1000000);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] b;
            b = ($urandom_range(0, 7) == 0) ? 16'($urandom) : bcd_value;
            applyStimulus(b,
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
